msi_dcache_ctrl: RTL and testbench
==================================

MSI_DCACHE_CTRL -- requirements
Module: msi_dcache_ctrl

Interface
REQ-001 SHALL take parameters: DATA_W, default 16, word width; WORDS, default 4, words per line (power of 2, >=2); SETS, default 64, direct-mapped sets (power of 2); ADDR_W, default 13, word address width.
REQ-002 SHALL derive localparams: LINE_W=DATA_W*WORDS; OFF_W=log2(WORDS); IDX_W=log2(SETS); TAG_W=ADDR_W-IDX_W-OFF_W.
REQ-003 SHALL have one clock and a synchronous, active-low reset; both are listed first below.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 cpu_re / cpu_we  in  1 each  CPU read/write request; level-held until cpu_rdy; never both high.
REQ-007 cpu_addr  in  ADDR_W  CPU word address.
REQ-008 cpu_wr_data  in  DATA_W  write word.
REQ-009 cpu_rd_data  out  DATA_W  read word; valid when cpu_rdy and cpu_re.
REQ-010 cpu_rdy  out  1  request complete this cycle.
REQ-011 bus_req  out  1  bus request; bus_grant  in  1  grant.
REQ-012 bus_cmd  out  2  NONE/BUSRD/BUSRDX/UPGR; bus_addr  out  ADDR_W-OFF_W  line address.
REQ-013 mem_re / mem_we  out  1 each; mem_addr  out  ADDR_W-OFF_W; mem_wr_line  out  LINE_W; mem_rd_line  in  LINE_W; mem_rdy  in  1  memory done.
REQ-014 snoop_valid  in  1; snoop_cmd  in  2; snoop_addr  in  ADDR_W-OFF_W  remote bus transaction.
REQ-015 snoop_hit  out  1; snoop_flush  out  1; snoop_line  out  LINE_W  supplies M data.

Function
REQ-016 States: IDLE, UPGRADE, EVICT, FILL; per-line state I/S/M plus TAG_W tag.
REQ-017 IDLE read hit (S or M): cpu_rdy=1 and cpu_rd_data=word[cpu_addr offset] in the same cycle (combinational).
REQ-018 IDLE write hit M: word merged into line at rising edge, cpu_rdy=1 the same cycle, state stays M.
REQ-019 IDLE write hit S: cpu_rdy=0 -> UPGRADE; bus_req=1, bus_cmd=UPGR until bus_grant; grant cycle writes word, state to M, cpu_rdy=1 -> IDLE.
REQ-020 Miss, victim M: -> EVICT; bus_req=1 until grant; then mem_we=1, mem_addr={victim tag,index}, mem_wr_line=victim line held until mem_rdy -> FILL.
REQ-021 Miss, victim I/S: -> FILL directly; S victim is silently dropped.
REQ-022 FILL: bus_req=1, bus_cmd=BUSRD (read) or BUSRDX (write) until grant; then mem_re=1 until mem_rdy; on mem_rdy, line written (write: word merged, state M; read: state S), cpu_rdy=0 -> IDLE; the held request then hits (miss latency = grant wait + mem latency + 2).
REQ-023 bus_req and mem_re/mem_we SHALL stay asserted continuously once raised until their respective grant/mem_rdy.
REQ-024 Snoops processed every cycle in every state, against the line at snoop_addr index with matching tag and state != I: snoop_hit=1.
REQ-025 Snoop BUSRD on M: snoop_flush=1, snoop_line=line, state to S; on S: no change.
REQ-026 Snoop BUSRDX on M: flush as REQ-025, state to I; BUSRDX/UPGR on S: state to I.
REQ-027 Snoop in IDLE same set as CPU request: snoop applied first; cpu_rdy=0 that cycle; CPU request re-evaluated next cycle.
REQ-028 UPGRADE with same line invalidated by snoop before grant: bus_cmd switches to BUSRDX, state -> FILL.
REQ-029 EVICT with victim invalidated/flushed by snoop before grant: abandon write-back, -> FILL.
REQ-030 snoop_valid never coincides with own bus_grant (bus guarantee); no arbitration needed.

Reset
REQ-031 rst_n low at a rising edge: state IDLE, all line states I, in any state, aborting any transaction.
REQ-032 Outputs during/after reset: cpu_rdy, bus_req, mem_re, mem_we, snoop_hit, snoop_flush = 0; bus_cmd=NONE; data outputs don't-care.

Structure
REQ-033 blk_state_t (I/S/M) and bus_cmd_t encodings SHALL live in package common.
REQ-034 Tag/state/data storage SHALL be sub-module msi_line_array (one CPU read/write port, one snoop read/state-write port, parameterised).

Verification
REQ-035 Read 0x0040 cold, mem returns line 0x4444_3333_2222_1111 -> BUSRD, state S, cpu_rd_data=0x1111.
REQ-036 Write 0xBEEF to 0x0041 hit S -> UPGR, grant -> state M, subsequent read 0x0041=0xBEEF.
REQ-037 Read 0x0840 (same index, other tag) with M victim -> mem_we with old line before mem_re of new line.
REQ-038 Snoop BUSRD on M line 0x0010 -> snoop_flush=1, snoop_line=line, state S same edge.
REQ-039 In UPGRADE, snoop UPGR same line before grant -> bus_cmd BUSRDX, final state M.
REQ-040 rst_n low during FILL with mem_re high -> next cycle mem_re=0, prior hit now misses.

Source files
------------

// File: rtl/msi_dcache_ctrl_pkg.sv
// Shared encodings for the MSI data-cache controller and its line array.
// Bus command values follow the order NONE/BUSRD/BUSRDX/UPGR.
package common;
  typedef enum logic [1:0] {
    BLK_I = 2'd0,
    BLK_S = 2'd1,
    BLK_M = 2'd2
  } blk_state_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_BUSRD  = 2'd1,
    CMD_BUSRDX = 2'd2,
    CMD_UPGR   = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPGRADE,
    ST_EVICT,
    ST_FILL
  } ctrl_state_t;
endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped tag/state/data storage: combinational reads on a CPU port and a snoop port.
// CPU port writes a whole entry; snoop port writes state only and loses to a same-set CPU write.
module msi_line_array
  import common::*;
#(
  parameter int LINE_W = 64,
  parameter int SETS   = 64,
  parameter int TAG_W  = 5,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  cpu_idx_i,
  output blk_state_t        cpu_state_o,
  output logic [TAG_W-1:0]  cpu_tag_o,
  output logic [LINE_W-1:0] cpu_line_o,
  input  logic              cpu_we_i,
  input  blk_state_t        cpu_state_i,
  input  logic [TAG_W-1:0]  cpu_tag_i,
  input  logic [LINE_W-1:0] cpu_line_i,
  input  logic [IDX_W-1:0]  snp_idx_i,
  output blk_state_t        snp_state_o,
  output logic [TAG_W-1:0]  snp_tag_o,
  output logic [LINE_W-1:0] snp_line_o,
  input  logic              snp_we_i,
  input  blk_state_t        snp_state_i
);

  blk_state_t        state_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS];
  logic [LINE_W-1:0] data_q  [SETS];

  assign cpu_state_o = state_q[cpu_idx_i];
  assign cpu_tag_o   = tag_q[cpu_idx_i];
  assign cpu_line_o  = data_q[cpu_idx_i];
  assign snp_state_o = state_q[snp_idx_i];
  assign snp_tag_o   = tag_q[snp_idx_i];
  assign snp_line_o  = data_q[snp_idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) state_q[i] <= BLK_I;
    end else begin
      if (snp_we_i) state_q[snp_idx_i] <= snp_state_i;
      if (cpu_we_i) state_q[cpu_idx_i] <= cpu_state_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cpu_we_i) begin
      tag_q[cpu_idx_i]  <= cpu_tag_i;
      data_q[cpu_idx_i] <= cpu_line_i;
    end
  end

endmodule

// File: rtl/msi_dcache_ctrl.sv
// Direct-mapped write-back MSI data cache controller with bus snooping.
// Hits complete combinationally; misses/upgrades hold the CPU until the bus and memory finish.
module msi_dcache_ctrl
  import common::*;
#(
  parameter int DATA_W = 16,
  parameter int WORDS  = 4,
  parameter int SETS   = 64,
  parameter int ADDR_W = 13,
  localparam int LINE_W = DATA_W * WORDS,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int LA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rdy,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [1:0]        bus_cmd,
  output logic [LA_W-1:0]   bus_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LA_W-1:0]   mem_addr,
  output logic [LINE_W-1:0] mem_wr_line,
  input  logic [LINE_W-1:0] mem_rd_line,
  input  logic              mem_rdy,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [LA_W-1:0]   snoop_addr,
  output logic              snoop_hit,
  output logic              snoop_flush,
  output logic [LINE_W-1:0] snoop_line
);

  ctrl_state_t state_q, state_d;
  logic        gnt_q, gnt_d;

  logic [TAG_W-1:0] cpu_tag, snp_tag, c_tag, s_tag, arr_wtag;
  logic [IDX_W-1:0] cpu_idx, snp_idx;
  logic [OFF_W-1:0] cpu_off;
  blk_state_t       c_state, s_state, arr_wstate, snp_wstate;
  logic [LINE_W-1:0] c_line, s_line, hit_line, fill_line, arr_wline;
  logic arr_we, snp_we, cpu_hit, req, conflict, snp_hit_c, snp_flush_c;
  logic rdy_c, bus_req_c, mem_re_c, mem_we_c;
  bus_cmd_t bus_cmd_c;

  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
  assign cpu_off = cpu_addr[OFF_W-1:0];
  assign snp_tag = snoop_addr[LA_W-1 -: TAG_W];
  assign snp_idx = snoop_addr[IDX_W-1:0];

  msi_line_array #(
    .LINE_W(LINE_W),
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_idx_i  (cpu_idx),
    .cpu_state_o(c_state),
    .cpu_tag_o  (c_tag),
    .cpu_line_o (c_line),
    .cpu_we_i   (arr_we),
    .cpu_state_i(arr_wstate),
    .cpu_tag_i  (arr_wtag),
    .cpu_line_i (arr_wline),
    .snp_idx_i  (snp_idx),
    .snp_state_o(s_state),
    .snp_tag_o  (s_tag),
    .snp_line_o (s_line),
    .snp_we_i   (snp_we),
    .snp_state_i(snp_wstate)
  );

  assign req         = cpu_re | cpu_we;
  assign cpu_hit     = (c_state != BLK_I) && (c_tag == cpu_tag);
  assign conflict    = snoop_valid && (snp_idx == cpu_idx);
  assign cpu_rd_data = c_line[int'(cpu_off)*DATA_W +: DATA_W];
  assign mem_wr_line = c_line;

  always_comb begin
    hit_line = c_line;
    hit_line[int'(cpu_off)*DATA_W +: DATA_W] = cpu_wr_data;
    fill_line = mem_rd_line;
    if (cpu_we) fill_line[int'(cpu_off)*DATA_W +: DATA_W] = cpu_wr_data;
  end

  // Snoop side: runs every cycle regardless of controller state.
  assign snp_hit_c = snoop_valid && (s_state != BLK_I) && (s_tag == snp_tag);

  always_comb begin
    snp_we      = 1'b0;
    snp_wstate  = BLK_I;
    snp_flush_c = 1'b0;
    if (snp_hit_c) begin
      case (bus_cmd_t'(snoop_cmd))
        CMD_BUSRD: if (s_state == BLK_M) begin
          snp_flush_c = 1'b1;
          snp_we      = 1'b1;
          snp_wstate  = BLK_S;
        end
        CMD_BUSRDX: begin
          snp_flush_c = (s_state == BLK_M);
          snp_we      = 1'b1;
        end
        CMD_UPGR: snp_we = (s_state == BLK_S);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rdy_c      = 1'b0;
    bus_req_c  = 1'b0;
    bus_cmd_c  = CMD_NONE;
    mem_re_c   = 1'b0;
    mem_we_c   = 1'b0;
    bus_addr   = {cpu_tag, cpu_idx};
    mem_addr   = {cpu_tag, cpu_idx};
    arr_we     = 1'b0;
    arr_wstate = BLK_M;
    arr_wtag   = cpu_tag;
    arr_wline  = hit_line;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 1'b0;
        if (req && !conflict) begin
          if (cpu_hit) begin
            if (cpu_re) begin
              rdy_c = 1'b1;
            end else if (c_state == BLK_M) begin
              rdy_c  = 1'b1;
              arr_we = 1'b1;
            end else begin
              state_d = ST_UPGRADE;
            end
          end else begin
            state_d = (c_state == BLK_M) ? ST_EVICT : ST_FILL;
          end
        end
      end
      ST_UPGRADE: begin
        bus_req_c = 1'b1;
        if (cpu_hit && c_state == BLK_S) begin
          bus_cmd_c = CMD_UPGR;
          if (bus_grant) begin
            rdy_c   = 1'b1;
            arr_we  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          // Lost the S copy to a snoop: a full read-exclusive is now required.
          bus_cmd_c = CMD_BUSRDX;
          gnt_d     = bus_grant;
          state_d   = ST_FILL;
        end
      end
      ST_EVICT: begin
        mem_addr = {c_tag, cpu_idx};
        if (!gnt_q) begin
          bus_req_c = 1'b1;
          if (c_state != BLK_M) begin
            bus_cmd_c = cpu_we ? CMD_BUSRDX : CMD_BUSRD;
            gnt_d     = bus_grant;
            state_d   = ST_FILL;
          end else begin
            bus_addr = {c_tag, cpu_idx};
            gnt_d    = bus_grant;
          end
        end else begin
          mem_we_c = 1'b1;
          if (mem_rdy) begin
            arr_we     = 1'b1;
            arr_wstate = BLK_I;
            arr_wtag   = c_tag;
            arr_wline  = c_line;
            gnt_d      = 1'b0;
            state_d    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (!gnt_q) begin
          bus_req_c = 1'b1;
          bus_cmd_c = cpu_we ? CMD_BUSRDX : CMD_BUSRD;
          gnt_d     = bus_grant;
        end else begin
          mem_re_c = 1'b1;
          if (mem_rdy) begin
            arr_we     = 1'b1;
            arr_wstate = cpu_we ? BLK_M : BLK_S;
            arr_wline  = fill_line;
            gnt_d      = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  assign cpu_rdy     = rst_n & rdy_c;
  assign bus_req     = rst_n & bus_req_c;
  assign bus_cmd     = rst_n ? bus_cmd_c : CMD_NONE;
  assign mem_re      = rst_n & mem_re_c;
  assign mem_we      = rst_n & mem_we_c;
  assign snoop_hit   = rst_n & snp_hit_c;
  assign snoop_flush = rst_n & snp_flush_c;
  assign snoop_line  = s_line;

endmodule

// File: tb/tb_msi_dcache_ctrl.sv
// Directed bench for msi_dcache_ctrl: fills, upgrade, eviction, snoops and reset abort.
module tb_msi_dcache_ctrl;
  localparam logic [1:0] C_NONE = 2'd0, C_RD = 2'd1, C_RDX = 2'd2, C_UPGR = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cpu_re, cpu_we, cpu_rdy, bus_req, bus_grant;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wr_data, cpu_rd_data;
  logic [1:0]  bus_cmd, snoop_cmd;
  logic [10:0] bus_addr, mem_addr, snoop_addr;
  logic        mem_re, mem_we, mem_rdy, snoop_valid, snoop_hit, snoop_flush;
  logic [63:0] mem_wr_line, mem_rd_line, snoop_line;

  int n_cmp = 0;
  int n_err = 0;

  msi_dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_rdy(cpu_rdy),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_rdy(mem_rdy),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_flush(snoop_flush), .snoop_line(snoop_line)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic grant();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
  endtask

  task automatic mem_done(input logic [63:0] line);
    mem_rd_line = line;
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    bus_grant = 1'b0; mem_rd_line = '0; mem_rdy = 1'b0;
    snoop_valid = 1'b0; snoop_cmd = C_NONE; snoop_addr = '0;
    repeat (3) tick();
    settle();
    check_eq("rst_cpu_rdy", cpu_rdy, 0);
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_bus_cmd", bus_cmd, C_NONE);
    check_eq("rst_mem_re", mem_re, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_snoop_hit", snoop_hit, 0);
    check_eq("rst_snoop_flush", snoop_flush, 0);
    tick();
    rst_n = 1'b1;
    settle();
    check_eq("post_rst_bus_req", bus_req, 0);

    // Cold read of 0x0040: BUSRD fill, word 0.
    cpu_re = 1'b1; cpu_addr = 13'h0040;
    settle();
    check_eq("cold_miss_rdy", cpu_rdy, 0);
    tick(); settle();
    check_eq("fill_bus_req", bus_req, 1);
    check_eq("fill_bus_cmd", bus_cmd, C_RD);
    check_eq("fill_bus_addr", bus_addr, 11'h010);
    grant(); settle();
    check_eq("fill_mem_re", mem_re, 1);
    check_eq("fill_mem_addr", mem_addr, 11'h010);
    check_eq("fill_bus_req_drop", bus_req, 0);
    mem_done(64'h4444_3333_2222_1111); settle();
    check_eq("fill_hit_rdy", cpu_rdy, 1);
    check_eq("fill_hit_data", cpu_rd_data, 16'h1111);
    cpu_addr = 13'h0043; settle();
    check_eq("hit_word3", cpu_rd_data, 16'h4444);

    // Write hit on S: upgrade, then read back.
    tick();
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 13'h0041; cpu_wr_data = 16'hBEEF;
    settle();
    check_eq("wr_s_rdy", cpu_rdy, 0);
    tick(); settle();
    check_eq("upg_bus_cmd", bus_cmd, C_UPGR);
    tick(); settle();
    check_eq("upg_bus_req_held", bus_req, 1);
    bus_grant = 1'b1; settle();
    check_eq("upg_grant_rdy", cpu_rdy, 1);
    tick();
    bus_grant = 1'b0; cpu_we = 1'b0; cpu_re = 1'b1;
    settle();
    check_eq("upg_rd_data", cpu_rd_data, 16'hBEEF);
    check_eq("upg_rd_rdy", cpu_rdy, 1);

    // Conflicting tag with an M victim: write-back precedes the fill.
    tick();
    cpu_addr = 13'h0840;
    settle();
    check_eq("evict_miss_rdy", cpu_rdy, 0);
    tick(); settle();
    check_eq("evict_bus_req", bus_req, 1);
    check_eq("evict_no_mem_re", mem_re, 0);
    grant(); settle();
    check_eq("evict_mem_we", mem_we, 1);
    check_eq("evict_mem_addr", mem_addr, 11'h010);
    check_eq("evict_line", mem_wr_line, 64'h4444_3333_BEEF_1111);
    check_eq("evict_mem_re_low", mem_re, 0);
    tick(); settle();
    check_eq("evict_mem_we_held", mem_we, 1);
    mem_done(64'h0); settle();
    check_eq("refill_mem_we_low", mem_we, 0);
    check_eq("refill_bus_cmd", bus_cmd, C_RD);
    check_eq("refill_bus_addr", bus_addr, 11'h210);
    grant(); settle();
    check_eq("refill_mem_re", mem_re, 1);
    check_eq("refill_mem_addr", mem_addr, 11'h210);
    mem_done(64'hDDDD_CCCC_BBBB_AAAA); settle();
    check_eq("refill_rd_data", cpu_rd_data, 16'hAAAA);

    // Write miss over an S victim: BUSRDX fill straight to M.
    tick();
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 13'h0040; cpu_wr_data = 16'h1234;
    tick(); settle();
    check_eq("wmiss_bus_cmd", bus_cmd, C_RDX);
    check_eq("wmiss_no_mem_we", mem_we, 0);
    grant();
    mem_done(64'h4444_3333_BEEF_1111); settle();
    check_eq("wmiss_rdy", cpu_rdy, 1);

    // Snoop BUSRD on M line 0x010, colliding with a CPU read of the same set.
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 13'h0041;
    snoop_valid = 1'b1; snoop_cmd = C_RD; snoop_addr = 11'h010;
    settle();
    check_eq("snp_m_hit", snoop_hit, 1);
    check_eq("snp_m_flush", snoop_flush, 1);
    check_eq("snp_m_line", snoop_line, 64'h4444_3333_BEEF_1234);
    check_eq("snp_conflict_rdy", cpu_rdy, 0);
    tick();
    snoop_valid = 1'b0;
    settle();
    check_eq("after_snp_rdy", cpu_rdy, 1);
    check_eq("after_snp_data", cpu_rd_data, 16'hBEEF);
    snoop_valid = 1'b1; settle();
    check_eq("snp_s_hit", snoop_hit, 1);
    check_eq("snp_s_no_flush", snoop_flush, 0);

    // Upgrade that loses its S copy to a remote UPGR before grant.
    tick();
    snoop_valid = 1'b0;
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 13'h0043; cpu_wr_data = 16'hCAFE;
    tick(); settle();
    check_eq("upg2_bus_cmd", bus_cmd, C_UPGR);
    snoop_valid = 1'b1; snoop_cmd = C_UPGR; snoop_addr = 11'h010;
    settle();
    check_eq("upg2_snp_hit", snoop_hit, 1);
    tick();
    snoop_valid = 1'b0;
    settle();
    check_eq("upg2_switch_cmd", bus_cmd, C_RDX);
    check_eq("upg2_req_held", bus_req, 1);
    tick(); settle();
    check_eq("upg2_fill_cmd", bus_cmd, C_RDX);
    grant();
    mem_done(64'h8888_7777_6666_5555); settle();
    check_eq("upg2_rdy", cpu_rdy, 1);
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1;
    settle();
    check_eq("upg2_rd_data", cpu_rd_data, 16'hCAFE);
    tick();
    cpu_re = 1'b0;
    snoop_valid = 1'b1; snoop_cmd = C_RDX; snoop_addr = 11'h010;
    settle();
    check_eq("upg2_m_flush", snoop_flush, 1);
    check_eq("upg2_m_line", snoop_line, 64'hCAFE_7777_6666_5555);
    tick(); settle();
    check_eq("after_rdx_no_hit", snoop_hit, 0);
    snoop_valid = 1'b0;

    // Reset while a fill has mem_re up.
    cpu_re = 1'b1; cpu_addr = 13'h0100;
    tick();
    grant();
    mem_done(64'h1003_1002_1001_1000); settle();
    check_eq("pre_rst_hit_data", cpu_rd_data, 16'h1000);
    check_eq("pre_rst_hit_rdy", cpu_rdy, 1);
    tick();
    cpu_addr = 13'h0200;
    tick();
    grant(); settle();
    check_eq("pre_rst_mem_re", mem_re, 1);
    rst_n = 1'b0;
    tick(); settle();
    check_eq("rst_abort_mem_re", mem_re, 0);
    check_eq("rst_abort_bus_req", bus_req, 0);
    rst_n = 1'b1; cpu_addr = 13'h0100;
    settle();
    check_eq("rst_prior_hit_miss", cpu_rdy, 0);
    check_eq("rst_idle_mem_re", mem_re, 0);
    tick(); settle();
    check_eq("rst_refetch_req", bus_req, 1);
    rst_n = 1'b0; cpu_re = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
